sbilinear_sched: RTL
====================

Name: sbilinear_sched

Overview:
Tile-walking scheduler that sequences the shift-based bilinear interpolation datapath.
- Walks an output tile in raster order and derives the fixed-point source coordinate of each output pixel.
- Fetches the four neighbours from a 1-cycle-latency image read port and issues one request per pixel to the interpolator.
- Returns each result on a valid/ready output stream.
- Sits between the frame buffer and the warp/resample output stage.

Parameters:
DATA_W, 16, signed pixel width (memory, interpolator and output stream)
FRAC_BITS, 8, fractional bits of coordinates, steps and interpolator frac_x/frac_y
COORD_W, 16, unsigned coordinate width, Q(COORD_W-FRAC_BITS).FRAC_BITS
IMG_W, 64, source image width in pixels
IMG_H, 64, source image height in pixels
DIM_W, 8, width of the tile-size configuration fields

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
cfg_base_x  in  COORD_W  source x of output pixel (0,0)
cfg_base_y  in  COORD_W  source y of output pixel (0,0)
cfg_step_x  in  COORD_W  source x increment per output column
cfg_step_y  in  COORD_W  source y increment per output row
cfg_out_w  in  DIM_W  tile width in output pixels
cfg_out_h  in  DIM_W  tile height in output pixels
busy  out  1  high from start acceptance until return to IDLE
done  out  1  one-cycle pulse at tile completion
mem_rd_en  out  1  read strobe
mem_rd_addr  out  $clog2(IMG_W*IMG_H)  row-major address iy*IMG_W+ix
mem_rd_data  in  DATA_W  read data, valid the cycle after mem_rd_en
interp_valid  out  1  interpolator request
interp_v00/v01/v10/v11  out  DATA_W each  neighbours (y,x)/(y,x+1)/(y+1,x)/(y+1,x+1)
interp_frac_x, interp_frac_y  out  FRAC_BITS  fractional coordinate
interp_out  in  DATA_W  interpolator result
interp_valid_out  in  1  interpolator result valid
out_data  out  DATA_W  interpolated pixel
out_valid  out  1  output valid
out_ready  in  1  downstream ready
out_last  out  1  high with the final pixel of the tile

Behaviour:
- Reset: all outputs 0, state IDLE, counters and coordinate accumulators cleared. Reset mid-tile abandons the tile with no done pulse.
- Config is sampled at start acceptance. start is ignored outside IDLE.
- States:
  - IDLE: on start, go to RD.
  - RD: 4 cycles, k=0..3; mem_rd_en=1; addresses in order 00, 01, 10, 11. Go to RDW.
  - RDW: 1 cycle; capture the last read.
  - ISSUE: 1 cycle; interp_valid=1 with registered v and frac.
  - CAPT: wait for interp_valid_out; register interp_out.
  - OUT: out_valid=1 until out_ready. On handshake, go to RD for the next pixel, or to IDLE with done=1 if out_last.
- Data return: read k issued in cycle t is captured in cycle t+1.
- Timing: start accepted at cycle 0 → reads in cycles 1-4 → interp_valid in cycle 6 → out_valid from cycle 8. Pixel period is 8 cycles when out_ready=1.
- Coordinates:
  - ix = cur_x>>FRAC_BITS, frac_x = cur_x[FRAC_BITS-1:0]; y likewise.
  - x0 = min(ix, IMG_W-1), x1 = min(ix+1, IMG_W-1); y0/y1 likewise with IMG_H.
  - frac is forwarded unchanged even when clamped.
- Advance on each output handshake:
  - Not at the end of a row: cur_x += step_x, ox++.
  - At ox==out_w-1: ox=0, cur_x=base_x, cur_y += step_y, oy++.
  - Additions wrap modulo 2^COORD_W.
- out_last = (ox==out_w-1)&&(oy==out_h-1).
- out_data, out_valid and out_last are held stable while out_valid&&!out_ready.
- cfg_out_w==0 or cfg_out_h==0: busy for 1 cycle, then done pulse; no reads, no output.
- interp_valid_out asserted outside CAPT is ignored.

Optional Feature:
SBI_PERF_CNT_EN
- Defined: adds 32-bit output ports perf_pix_cnt (output handshakes) and perf_stall_cnt (cycles with out_valid&&!out_ready). Both clear on start acceptance and on reset, and saturate at all-ones.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package sbilinear_pkg: state enum (IDLE, RD, RDW, ISSUE, CAPT, OUT), neighbour index constants N00..N11, and a coord-split helper function (integer/fraction with clamp).
- One sub-module, sbilinear_coord_gen: holds the cur_x/cur_y/ox/oy accumulators and produces x0, x1, y0, y1, frac and last; it advances on an advance strobe and loads on a load strobe.

Test Plan:
- 1x1 tile, base (2.5, 3.25) [0x0280, 0x0340] → addrs 194, 195, 258, 259 in cycles 1-4; frac_x=128, frac_y=64; interp_valid at cycle 6; out_valid+out_last at cycle 8; done on the handshake.
- 2x2 tile, base (0,0), steps 1.0 [0x0100], out_ready=1 → 4 outputs at 8-cycle spacing; first-read addrs 0, 1, 64, 65 in raster order; out_last only on the 4th; one done.
- Border clamp, base (63.5, 63.0), 1x1 → addrs 4095, 4095, 4095, 4095; frac_x=128, frac_y=0.
- Backpressure: out_ready low for 5 cycles on pixel 0 → out_data held constant, no new reads; with SBI_PERF_CNT_EN, perf_stall_cnt=5 and perf_pix_cnt=4 at the end of the 2x2 tile.
- Start while busy plus reset at cycle 10 of a 2x2 tile → second start ignored; after reset, outputs 0, no done, and a fresh start runs normally.
- cfg_out_w=0 → busy 1 cycle, done pulse, zero reads, out_valid never asserted.

Source files
------------

// File: rtl/sbilinear_pkg.sv
// Shared state encoding, neighbour indices and coordinate helper for the
// bilinear tile scheduler.
package sbilinear_pkg;

    typedef enum logic [2:0] {IDLE, RD, RDW, ISSUE, CAPT, OUT} state_t;

    localparam logic [1:0] N00 = 2'd0;
    localparam logic [1:0] N01 = 2'd1;
    localparam logic [1:0] N10 = 2'd2;
    localparam logic [1:0] N11 = 2'd3;

    // Integer part of a fixed-point coordinate (plus optional +1 neighbour
    // offset), clamped to the last valid index lim-1.
    function automatic logic [31:0] coord_split(input logic [31:0] c, input int fb,
                                                input int lim, input logic off);
        logic [31:0] ip;
        ip = (c >> fb) + {31'd0, off};
        return (ip > 32'(lim - 1)) ? 32'(lim - 1) : ip;
    endfunction

endpackage

// File: rtl/sbilinear_sched_if.sv
// Image read port, interpolator request/response and output stream of the
// bilinear tile scheduler.
interface sbilinear_sched_if #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ADDR_W    = 12
);
    logic                        mem_rd_en;
    logic [ADDR_W-1:0]           mem_rd_addr;
    logic signed [DATA_W-1:0]    mem_rd_data;

    logic                        interp_valid;
    logic signed [DATA_W-1:0]    interp_v00, interp_v01, interp_v10, interp_v11;
    logic [FRAC_BITS-1:0]        interp_frac_x, interp_frac_y;
    logic signed [DATA_W-1:0]    interp_out;
    logic                        interp_valid_out;

    logic signed [DATA_W-1:0]    out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output mem_rd_en, mem_rd_addr, input mem_rd_data,
        output interp_valid, interp_v00, interp_v01, interp_v10, interp_v11,
        output interp_frac_x, interp_frac_y, input interp_out, interp_valid_out,
        output out_data, out_valid, out_last, input out_ready
    );

    modport slave (
        input mem_rd_en, mem_rd_addr, output mem_rd_data,
        input interp_valid, interp_v00, interp_v01, interp_v10, interp_v11,
        input interp_frac_x, interp_frac_y, output interp_out, interp_valid_out,
        input out_data, out_valid, out_last, output out_ready
    );
endinterface

// File: rtl/sbilinear_coord_gen.sv
// Raster-order coordinate accumulator: tracks the output position and the
// fixed-point source coordinate, and splits it into clamped neighbour indices.
module sbilinear_coord_gen
    import sbilinear_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int COORD_W   = 16,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int DIM_W     = 8,
    parameter int XW        = $clog2(IMG_W),
    parameter int YW        = $clog2(IMG_H)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 adv,
    input  logic [COORD_W-1:0]   base_x,
    input  logic [COORD_W-1:0]   base_y,
    input  logic [COORD_W-1:0]   step_x,
    input  logic [COORD_W-1:0]   step_y,
    input  logic [DIM_W-1:0]     out_w,
    input  logic [DIM_W-1:0]     out_h,
    output logic [XW-1:0]        x0,
    output logic [XW-1:0]        x1,
    output logic [YW-1:0]        y0,
    output logic [YW-1:0]        y1,
    output logic [FRAC_BITS-1:0] frac_x,
    output logic [FRAC_BITS-1:0] frac_y,
    output logic                 last
);
    logic [COORD_W-1:0] cur_x, cur_y, bx, sx, sy;
    logic [DIM_W-1:0]   ox, oy, wm1, hm1;
    logic               row_end;

    assign row_end = (ox == wm1);
    assign last    = row_end && (oy == hm1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x <= '0; cur_y <= '0; bx <= '0; sx <= '0; sy <= '0;
            ox <= '0; oy <= '0; wm1 <= '0; hm1 <= '0;
        end else if (load) begin
            cur_x <= base_x; cur_y <= base_y; bx <= base_x;
            sx <= step_x; sy <= step_y;
            wm1 <= out_w - DIM_W'(1); hm1 <= out_h - DIM_W'(1);
            ox <= '0; oy <= '0;
        end else if (adv) begin
            if (row_end) begin
                ox    <= '0;
                oy    <= oy + DIM_W'(1);
                cur_x <= bx;
                cur_y <= cur_y + sy;
            end else begin
                ox    <= ox + DIM_W'(1);
                cur_x <= cur_x + sx;
            end
        end
    end

    // Fraction passes through untouched even when the index is clamped.
    assign x0     = XW'(coord_split(32'(cur_x), FRAC_BITS, IMG_W, 1'b0));
    assign x1     = XW'(coord_split(32'(cur_x), FRAC_BITS, IMG_W, 1'b1));
    assign y0     = YW'(coord_split(32'(cur_y), FRAC_BITS, IMG_H, 1'b0));
    assign y1     = YW'(coord_split(32'(cur_y), FRAC_BITS, IMG_H, 1'b1));
    assign frac_x = cur_x[FRAC_BITS-1:0];
    assign frac_y = cur_y[FRAC_BITS-1:0];

endmodule

// File: rtl/sbilinear_sched.sv
// Tile-walking scheduler for the bilinear interpolator: fetch 4 neighbours,
// issue one request, stream the result. SBI_PERF_CNT_EN adds perf counters.
module sbilinear_sched
    import sbilinear_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int COORD_W   = 16,
    parameter int IMG_W     = 64,
    parameter int IMG_H     = 64,
    parameter int DIM_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COORD_W-1:0] cfg_base_x,
    input  logic [COORD_W-1:0] cfg_base_y,
    input  logic [COORD_W-1:0] cfg_step_x,
    input  logic [COORD_W-1:0] cfg_step_y,
    input  logic [DIM_W-1:0]   cfg_out_w,
    input  logic [DIM_W-1:0]   cfg_out_h,
    output logic               busy,
    output logic               done,
`ifdef SBI_PERF_CNT_EN
    output logic [31:0]        perf_pix_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    sbilinear_sched_if.master  bus
);
    localparam int ADDR_W = $clog2(IMG_W * IMG_H);
    localparam int XW     = $clog2(IMG_W);
    localparam int YW     = $clog2(IMG_H);

    state_t                   state;
    logic [1:0]               k;
    logic [3:0][DATA_W-1:0]   nbr;
    logic [XW-1:0]            x0, x1, xs;
    logic [YW-1:0]            y0, y1, ys;
    logic [FRAC_BITS-1:0]     frac_x, frac_y;
    logic                     last, start_acc, adv;

    // The IDLE cycle with busy still set is the zero-size tile's one busy cycle.
    assign start_acc = (state == IDLE) && !busy && start;
    assign adv       = (state == OUT) && bus.out_ready;

    sbilinear_coord_gen #(
        .FRAC_BITS(FRAC_BITS), .COORD_W(COORD_W), .IMG_W(IMG_W),
        .IMG_H(IMG_H), .DIM_W(DIM_W), .XW(XW), .YW(YW)
    ) u_coord (
        .clk(clk), .rst_n(rst_n), .load(start_acc), .adv(adv),
        .base_x(cfg_base_x), .base_y(cfg_base_y),
        .step_x(cfg_step_x), .step_y(cfg_step_y),
        .out_w(cfg_out_w), .out_h(cfg_out_h),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .frac_x(frac_x), .frac_y(frac_y), .last(last)
    );

    assign xs = k[0] ? x1 : x0;
    assign ys = k[1] ? y1 : y0;
    assign bus.mem_rd_addr = bus.mem_rd_en ? ADDR_W'(32'(ys) * 32'(IMG_W) + 32'(xs)) : '0;

    assign bus.interp_v00 = nbr[N00];
    assign bus.interp_v01 = nbr[N01];
    assign bus.interp_v10 = nbr[N10];
    assign bus.interp_v11 = nbr[N11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE; k <= '0; nbr <= '0;
            busy <= 1'b0; done <= 1'b0;
            bus.mem_rd_en <= 1'b0; bus.interp_valid <= 1'b0;
            bus.interp_frac_x <= '0; bus.interp_frac_y <= '0;
            bus.out_data <= '0; bus.out_valid <= 1'b0; bus.out_last <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (start) begin
                        busy <= 1'b1;
                        if (cfg_out_w != '0 && cfg_out_h != '0) begin
                            state <= RD; k <= N00; bus.mem_rd_en <= 1'b1;
                        end
                    end
                end
                RD: begin
                    // Read k-1 returns while read k is being issued.
                    if (k != N00) nbr[k - 2'd1] <= bus.mem_rd_data;
                    if (k == N11) begin
                        bus.mem_rd_en <= 1'b0;
                        state <= RDW;
                    end
                    k <= k + 2'd1;
                end
                RDW: begin
                    nbr[N11] <= bus.mem_rd_data;
                    bus.interp_frac_x <= frac_x;
                    bus.interp_frac_y <= frac_y;
                    bus.interp_valid <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: begin
                    bus.interp_valid <= 1'b0;
                    state <= CAPT;
                end
                CAPT: begin
                    if (bus.interp_valid_out) begin
                        bus.out_data  <= bus.interp_out;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= last;
                        state <= OUT;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        if (bus.out_last) begin
                            state <= IDLE; busy <= 1'b0; done <= 1'b1;
                        end else begin
                            state <= RD; k <= N00; bus.mem_rd_en <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SBI_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_pix_cnt <= '0; perf_stall_cnt <= '0;
        end else if (start_acc) begin
            perf_pix_cnt <= '0; perf_stall_cnt <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready && perf_pix_cnt != '1)
                perf_pix_cnt <= perf_pix_cnt + 32'd1;
            if (bus.out_valid && !bus.out_ready && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
